imem_line_cache: RTL and testbench
==================================

# imem_line_cache

Direct-mapped, read-only instruction cache placed between the CPU fetch port and the slow backing word memory. It responds to the CPU using the same request/valid handshake the `Memory` port 1 exposes: `MEM_RDEN1`, `MEM_ADDR1`, `MEM_DOUT1`, `memValid1`. On a miss it acts as the initiator toward the backing memory, filling an 8-word line one word at a time before answering the CPU.

## Interface
- `NUM_LINES`, default 16. Number of cache lines; power of 2, minimum 2. `IDX_W = log2(NUM_LINES)`.
- `ADDR_W`, default 14. Word-address width.
- Line size is fixed at 8 words, so the word offset is 3 bits.
- `MEM_CLK`, input, 1 bit. Single clock; all logic updates on its rising edge.
- `RST`, input, 1 bit. Synchronous, active-high reset.
- `MEM_RDEN1`, input, 1 bit. CPU read request; held high until `memValid1` is seen.
- `MEM_ADDR1`, input, ADDR_W bits. CPU word address.
- `MEM_DOUT1`, output, 32 bits. Read data; valid while `memValid1`=1.
- `memValid1`, output, 1 bit. One-cycle response pulse.
- `MAIN_RDEN`, output, 1 bit. Backing-memory read request.
- `MAIN_ADDR`, output, ADDR_W bits. Backing-memory word address.
- `MAIN_DOUT`, input, 32 bits. Backing-memory read data; valid while `MAIN_VALID`=1.
- `MAIN_VALID`, input, 1 bit. Backing-memory one-cycle response pulse; arbitrary latency ≥1 cycle.
- `HIT_CNT`, output, 16 bits. Count of CPU requests answered without a fill; saturates at 0xFFFF.
- `MISS_CNT`, output, 16 bits. Count of fills started; saturates at 0xFFFF.

## Operation
- Address split:
  - offset = `ADDR[2:0]`
  - index = `ADDR[IDX_W+2:3]`
  - tag = remaining upper bits.
- Storage: per-line valid bit, tag register, and 8×32 data words, all in flops.
- States:
  - IDLE
    - `MEM_RDEN1`=1 and hit (line valid and tags match): capture the addressed word into `MEM_DOUT1`, increment `HIT_CNT`, go to RESP.
    - `MEM_RDEN1`=1 and miss: capture the request address into `req_addr`, clear `fill_cnt`, increment `MISS_CNT`, go to FILL_REQ.
    - `MEM_RDEN1`=0: stay in IDLE.
  - FILL_REQ
    - Drive `MAIN_RDEN`=1 and `MAIN_ADDR={req_tag, req_idx, fill_cnt}`.
    - On `MAIN_VALID`: write `MAIN_DOUT` to data word `fill_cnt`.
      - `fill_cnt`<7: increment `fill_cnt`, go to FILL_GAP.
      - `fill_cnt`=7: set the line's tag and valid bit, load `MEM_DOUT1` with word `req_offset` (taking `MAIN_DOUT` directly when `req_offset`=7), go to RESP.
  - FILL_GAP: `MAIN_RDEN`=0 for exactly one cycle, then go to FILL_REQ. This gives the backing memory a distinct new request per word.
  - RESP: `memValid1`=1 for one cycle, then go to IDLE unconditionally. The request present in this cycle is ignored.
- Fill order is always word 0 to word 7; there is no critical-word-first.
- The line is not marked valid until the 8th word is written, so a partially filled line can never hit.
- `MEM_ADDR1` changes and `MEM_RDEN1` drops during a fill are ignored. The fill completes, the line is installed, and the RESP pulse is still issued.
- A miss overwrites the resident line at that index (direct-mapped replacement).
- Counters use 16-bit saturating increments and do not wrap.

## Timing
- Reset values:
  - state IDLE
  - all valid bits 0
  - `memValid1`=0, `MEM_DOUT1`=0
  - `MAIN_RDEN`=0, `MAIN_ADDR`=0
  - `HIT_CNT`=0, `MISS_CNT`=0
- Tags and data are not reset.
- `RST` during a fill aborts it. `MAIN_RDEN` is 0 in the cycle after the reset edge, and a `MAIN_VALID` arriving while `RST`=1 is discarded.
- Hit: request sampled at edge k; `memValid1`=1 during cycle k+1; the next request is accepted at edge k+2. Minimum hit turnaround is 2 cycles.
- Miss with backing latency L cycles per word (from the `MAIN_RDEN` rise to `MAIN_VALID`):
  - Response at request edge + 1 + 8·L + 7 gap cycles, ±1 for RESP registration.
  - The response must be the single cycle after the final `MAIN_VALID` edge.
- `MEM_DOUT1` holds its last value between responses.
- `MAIN_ADDR` is stable for the whole time `MAIN_RDEN`=1.

## Test plan
- Cold miss, `MEM_ADDR1`=0x0000, backing memory with 8-cycle delay:
  - Exactly 8 `MAIN_RDEN` pulses, addresses 0x0000 to 0x0007 in order, each separated by 1 low cycle.
  - One `memValid1` pulse the cycle after the last `MAIN_VALID`, with `MEM_DOUT1`=mem[0].
  - `MISS_CNT`=1.
- Reads of 0x0001 to 0x0007 after that fill:
  - Each returns `memValid1` 1 cycle after acceptance with the matching mem word.
  - `MAIN_RDEN` stays 0 throughout; `HIT_CNT`=7, `MISS_CNT`=1.
- Conflict at NUM_LINES=16:
  - Read 0x0000, then 0x0080 (same index 0, tag 1): a full refill at 0x0080 to 0x0087.
  - Re-read 0x0000: a third fill; `MISS_CNT`=3.
- Reset mid-fill:
  - Assert `RST` for 1 cycle after the 3rd `MAIN_VALID` of a fill for 0x0010: `MAIN_RDEN`=0 the next cycle and `memValid1` never pulses.
  - Re-read 0x0010: a full 8-word fill from 0x0010, with counters restarting from 0.
- Back-to-back sweep: hold `MEM_RDEN1`=1, step `MEM_ADDR1` through 0 to 16383 after each `memValid1`.
  - Every `MEM_DOUT1` equals the `otter_mem.mem` word.
  - `MISS_CNT`=2048, `HIT_CNT`=14336.
- Request dropped mid-fill: deassert `MEM_RDEN1` and change the address during the fill.
  - The fill still completes for the original line and `memValid1` pulses once.
  - A later read of that line hits.

Source files
------------

// File: rtl/imem_line_cache.sv
// Direct-mapped read-only instruction cache, 8-word lines, fills word 0..7 from backing memory on a miss.
// Latency: hit answers the cycle after the request edge; miss answers the cycle after the 8th MAIN_VALID.
// Backpressure: CPU holds MEM_RDEN1 until memValid1; backing memory gets one MAIN_RDEN pulse per word.
module imem_line_cache #(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W    = 14
) (
  input  logic              MEM_CLK,
  input  logic              RST,
  input  logic              MEM_RDEN1,
  input  logic [ADDR_W-1:0] MEM_ADDR1,
  output logic [31:0]       MEM_DOUT1,
  output logic              memValid1,
  output logic              MAIN_RDEN,
  output logic [ADDR_W-1:0] MAIN_ADDR,
  input  logic [31:0]       MAIN_DOUT,
  input  logic              MAIN_VALID,
  output logic [15:0]       HIT_CNT,
  output logic [15:0]       MISS_CNT
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 3;

  typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_GAP, RESP} state_t;

  state_t            state_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [NUM_LINES];
  logic [31:0]       data_q [NUM_LINES][8];

  logic [ADDR_W-1:0] req_addr_q;
  logic [2:0]        fill_cnt_q;
  logic [31:0]       dout_q;
  logic              resp_vld_q;
  logic              main_rden_q;
  logic [ADDR_W-1:0] main_addr_q;
  logic [15:0]       hit_cnt_q;
  logic [15:0]       miss_cnt_q;
  logic [15:0]       hit_cnt_d;
  logic [15:0]       miss_cnt_d;

  logic [2:0]        cpu_off;
  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic              cpu_hit;
  logic [2:0]        req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [31:0]       req_word;
  logic              fill_we;

  assign cpu_off = MEM_ADDR1[2:0];
  assign cpu_idx = MEM_ADDR1[IDX_W+2:3];
  assign cpu_tag = MEM_ADDR1[ADDR_W-1:IDX_W+3];
  assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  assign req_off = req_addr_q[2:0];
  assign req_idx = req_addr_q[IDX_W+2:3];
  assign req_tag = req_addr_q[ADDR_W-1:IDX_W+3];

  // The last fill word is not in the array yet when the response is loaded, so bypass it.
  assign req_word = (req_off == 3'd7) ? MAIN_DOUT : data_q[req_idx][req_off];

  // Words only land while a fill is requesting; stray or reset-time MAIN_VALID is dropped.
  assign fill_we = (state_q == FILL_REQ) && MAIN_VALID && !RST;

  assign hit_cnt_d  = (hit_cnt_q  == 16'hFFFF) ? hit_cnt_q  : hit_cnt_q  + 16'd1;
  assign miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;

  assign MEM_DOUT1 = dout_q;
  assign memValid1 = resp_vld_q;
  assign MAIN_RDEN = main_rden_q;
  assign MAIN_ADDR = main_addr_q;
  assign HIT_CNT   = hit_cnt_q;
  assign MISS_CNT  = miss_cnt_q;

  // Line storage: data words written as they arrive, tag written with the final word.
  always_ff @(posedge MEM_CLK) begin
    if (fill_we) begin
      data_q[req_idx][fill_cnt_q] <= MAIN_DOUT;
      if (fill_cnt_q == 3'd7) begin
        tag_q[req_idx] <= req_tag;
      end
    end
  end

  // Control FSM with registered CPU and backing-memory outputs.
  always_ff @(posedge MEM_CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      req_addr_q  <= '0;
      fill_cnt_q  <= 3'd0;
      dout_q      <= 32'd0;
      resp_vld_q  <= 1'b0;
      main_rden_q <= 1'b0;
      main_addr_q <= '0;
      hit_cnt_q   <= 16'd0;
      miss_cnt_q  <= 16'd0;
    end else begin
      resp_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MEM_RDEN1) begin
            if (cpu_hit) begin
              dout_q     <= data_q[cpu_idx][cpu_off];
              resp_vld_q <= 1'b1;
              hit_cnt_q  <= hit_cnt_d;
              state_q    <= RESP;
            end else begin
              // Victim line is invalidated up front so a partial fill can never hit.
              valid_q[cpu_idx] <= 1'b0;
              req_addr_q       <= MEM_ADDR1;
              fill_cnt_q       <= 3'd0;
              miss_cnt_q       <= miss_cnt_d;
              main_rden_q      <= 1'b1;
              main_addr_q      <= {MEM_ADDR1[ADDR_W-1:3], 3'd0};
              state_q          <= FILL_REQ;
            end
          end
        end
        FILL_REQ: begin
          if (MAIN_VALID) begin
            main_rden_q <= 1'b0;
            if (fill_cnt_q == 3'd7) begin
              valid_q[req_idx] <= 1'b1;
              dout_q           <= req_word;
              resp_vld_q       <= 1'b1;
              state_q          <= RESP;
            end else begin
              fill_cnt_q <= fill_cnt_q + 3'd1;
              state_q    <= FILL_GAP;
            end
          end
        end
        FILL_GAP: begin
          // One low cycle between words so each word is a distinct request.
          main_rden_q <= 1'b1;
          main_addr_q <= {req_addr_q[ADDR_W-1:3], fill_cnt_q};
          state_q     <= FILL_REQ;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_line_cache.sv
// Bench for imem_line_cache: directed scenarios plus randomized reads against a transaction-level cache model.
// Backing memory is a random word array served with a programmable per-word latency.
// Outputs are compared every cycle on the falling edge; key counts are also pinned with literals.
module tb_imem_line_cache;
  localparam int AW = 12;
  localparam int NL = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rden;
  logic [AW-1:0] addr;
  logic [31:0]   dout;
  logic          dvld;
  logic          main_rden;
  logic [AW-1:0] main_addr;
  logic [31:0]   main_dout;
  logic          main_valid;
  logic [15:0]   hit_cnt;
  logic [15:0]   miss_cnt;

  logic [31:0]   mem [1<<AW];
  logic [AW-1:0] fill_log [$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            n_pulses = 0;
  int            lat = 8;

  imem_line_cache #(.NUM_LINES(NL), .ADDR_W(AW)) dut (
    .MEM_CLK(clk), .RST(rst), .MEM_RDEN1(rden), .MEM_ADDR1(addr),
    .MEM_DOUT1(dout), .memValid1(dvld), .MAIN_RDEN(main_rden), .MAIN_ADDR(main_addr),
    .MAIN_DOUT(main_dout), .MAIN_VALID(main_valid), .HIT_CNT(hit_cnt), .MISS_CNT(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory: answers each MAIN_RDEN request after lat cycles with a one-cycle MAIN_VALID.
  initial begin : responder
    logic [AW-1:0] a;
    main_valid = 1'b0;
    main_dout  = 32'd0;
    forever begin
      @(posedge clk); #1;
      main_valid = 1'b0;
      main_dout  = $urandom;
      if (main_rden === 1'b1 && rst === 1'b0) begin
        a = main_addr;
        fill_log.push_back(a);
        for (int i = 0; i < lat; i++) begin
          @(posedge clk); #1;
        end
        main_valid = 1'b1;
        main_dout  = mem[a];
        n_pulses++;
      end
    end
  end

  // Transaction-level cache model; checks all outputs each cycle.
  initial begin : compare
    bit            started;
    int            phase;   // 0 free, 1 responding, 2 filling
    int            words;
    logic [AW-1:0] req;
    logic [AW-1:0] a;
    bit            mvalid [NL];
    logic [4:0]    mtag [NL];
    logic          exp_vld;
    logic [31:0]   exp_dout;
    logic [15:0]   hit_m;
    logic [15:0]   miss_m;
    logic          exp_rden;
    logic [AW-1:0] exp_maddr;
    bit            maddr_chk;
    started = 0; phase = 0; words = 0; req = '0;
    exp_vld = 1'b0; exp_dout = 32'd0; hit_m = 16'd0; miss_m = 16'd0;
    exp_rden = 1'b0; exp_maddr = '0; maddr_chk = 0;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("memValid1", 32'(dvld), 32'(exp_vld));
        chk("MEM_DOUT1", dout, exp_dout);
        chk("HIT_CNT", 32'(hit_cnt), 32'(hit_m));
        chk("MISS_CNT", 32'(miss_cnt), 32'(miss_m));
        chk("MAIN_RDEN", 32'(main_rden), 32'(exp_rden));
        if (maddr_chk) chk("MAIN_ADDR", 32'(main_addr), 32'(exp_maddr));
      end
      exp_vld   = 1'b0;
      maddr_chk = 0;
      if (rst === 1'b1) begin
        for (int i = 0; i < NL; i++) mvalid[i] = 0;
        phase = 0; hit_m = 16'd0; miss_m = 16'd0; exp_dout = 32'd0;
        exp_rden = 1'b0; exp_maddr = '0; maddr_chk = 1; started = 1;
      end else if (started) begin
        case (phase)
          0: begin
            exp_rden = 1'b0;
            if (rden === 1'b1) begin
              a = addr;
              if (mvalid[a[6:3]] && mtag[a[6:3]] == a[11:7]) begin
                if (hit_m != 16'hFFFF) hit_m = hit_m + 16'd1;
                exp_vld = 1'b1; exp_dout = mem[a]; phase = 1;
              end else begin
                if (miss_m != 16'hFFFF) miss_m = miss_m + 16'd1;
                mvalid[a[6:3]] = 0;
                req = a; words = 0; phase = 2;
                exp_rden = 1'b1; maddr_chk = 1; exp_maddr = {a[AW-1:3], 3'd0};
              end
            end
          end
          1: begin
            phase = 0; exp_rden = 1'b0;
          end
          default: begin
            if (main_valid === 1'b1) begin
              exp_rden = 1'b0;
              if (words == 7) begin
                mvalid[req[6:3]] = 1; mtag[req[6:3]] = req[11:7];
                exp_vld = 1'b1; exp_dout = mem[req]; phase = 1;
              end else begin
                words++;
              end
            end else begin
              exp_rden = 1'b1; maddr_chk = 1; exp_maddr = {req[AW-1:3], 3'(words)};
            end
          end
        endcase
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input bit hold, input bit drop);
    bit got;
    got = 0;
    rden = 1'b1; addr = a;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (dvld === 1'b1) begin
        got = 1;
        break;
      end
      if (drop && i == 4) begin
        rden = 1'b0; addr = AW'($urandom);
      end
    end
    chk("read_completes", 32'(got), 32'd1);
    if (!hold) rden = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; rden = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : driver
    int p0;
    int seen;
    for (int i = 0; i < (1<<AW); i++) mem[i] = $urandom;
    rst = 1'b1; rden = 1'b0; addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Cold miss at 0 with 8-cycle backing latency.
    lat = 8; p0 = n_pulses; fill_log.delete();
    do_read(12'h000, 0, 0);
    chk("cold_pulses", 32'(n_pulses - p0), 32'd8);
    chk("cold_log_size", 32'(fill_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("cold_fill_addr", 32'(fill_log[i]), 32'(i));
    chk("cold_dout", dout, mem[0]);
    chk("cold_miss_cnt", 32'(miss_cnt), 32'd1);

    // Hits on the rest of the line.
    lat = 2;
    for (int i = 1; i < 8; i++) do_read(AW'(i), 0, 0);
    chk("hits_no_fill", 32'(n_pulses - p0), 32'd8);
    chk("hits_hit_cnt", 32'(hit_cnt), 32'd7);
    chk("hits_miss_cnt", 32'(miss_cnt), 32'd1);

    // Conflict on index 0.
    do_read(12'h000, 0, 0);
    do_read(12'h080, 0, 0);
    do_read(12'h000, 0, 0);
    chk("conflict_miss_cnt", 32'(miss_cnt), 32'd3);
    chk("conflict_hit_cnt", 32'(hit_cnt), 32'd8);

    // Reset after the third word of a fill.
    lat = 3; p0 = n_pulses;
    rden = 1'b1; addr = 12'h010;
    for (int i = 0; i < 200 && n_pulses < p0 + 3; i++) begin
      @(posedge clk); #2;
    end
    chk("abort_reached_word3", 32'(n_pulses - p0), 32'd3);
    @(posedge clk); #1;
    rst = 1'b1; rden = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_main_rden", 32'(main_rden), 32'd0);
    chk("abort_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("abort_miss_cnt", 32'(miss_cnt), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (dvld === 1'b1) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    fill_log.delete();
    do_read(12'h010, 0, 0);
    chk("refill_log_size", 32'(fill_log.size()), 32'd8);
    chk("refill_first", 32'(fill_log[0]), 32'h010);
    chk("refill_last", 32'(fill_log[7]), 32'h017);
    chk("refill_miss_cnt", 32'(miss_cnt), 32'd1);

    // Request dropped mid-fill still installs the line.
    do_read(12'h200, 0, 1);
    chk("drop_miss_cnt", 32'(miss_cnt), 32'd2);
    idle(2);
    do_read(12'h203, 0, 0);
    do_read(12'h010, 0, 0);
    chk("drop_hit_cnt", 32'(hit_cnt), 32'd2);
    chk("drop_miss_cnt2", 32'(miss_cnt), 32'd2);

    // Back-to-back sweep of the whole address space.
    lat = 1;
    pulse_reset();
    for (int a = 0; a < (1<<AW); a++) do_read(AW'(a), 1, 0);
    rden = 1'b0;
    idle(2);
    chk("sweep_miss_cnt", 32'(miss_cnt), 32'd512);
    chk("sweep_hit_cnt", 32'(hit_cnt), 32'd3584);

    // Randomized reads over a small window to mix hits, conflicts and drops.
    for (int n = 0; n < 300; n++) begin
      lat = $urandom_range(1, 4);
      do_read(AW'($urandom_range(0, 1023)), bit'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      if (rden === 1'b0) idle($urandom_range(0, 3));
    end
    rden = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
